// File: rtl/solar_tracker_pkg.sv
// Shared definitions for the solar tracker servo PWM blocks.
//   - Direction encodings shared with the servo driver.
//   - PWM capture FSM state encoding.
//   - Default legal pulse-width limits (ticks).
//   - Helpers: saturating increment, direction classification.
package solar_tracker_pkg;

    localparam logic [1:0] DIR_STOP = 2'b00;
    localparam logic [1:0] DIR_CCW  = 2'b01;  // width increased
    localparam logic [1:0] DIR_CW   = 2'b10;  // width decreased

    localparam int unsigned PW_MIN_DEFAULT = 500;
    localparam int unsigned PW_MAX_DEFAULT = 2500;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StHigh = 2'b01,
        StLow  = 2'b10
    } pwm_state_e;

    // Increment on tick, but never past the limit.
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic tick,
                                            input logic [31:0] limit);
        return (tick && (cnt < limit)) ? cnt + 32'd1 : cnt;
    endfunction

    // Classify a width change; changes within the deadband report stop.
    // Done in 33 bits so the deadband addition cannot overflow.
    function automatic logic [1:0] pwm_direction(input logic [31:0] new_w,
                                                 input logic [31:0] old_w,
                                                 input logic [31:0] deadband);
        logic [32:0] w_new;
        logic [32:0] w_old;
        logic [32:0] w_db;
        w_new = {1'b0, new_w};
        w_old = {1'b0, old_w};
        w_db  = {1'b0, deadband};
        if (w_new > w_old + w_db) begin
            return DIR_CCW;
        end
        if (w_new + w_db < w_old) begin
            return DIR_CW;
        end
        return DIR_STOP;
    endfunction

endpackage

// File: rtl/pwm_edge_sync.sv
// Two-flop synchronizer plus edge detector for the PWM input.
//   i_clk   : system clock
//   i_rst   : asynchronous active-high reset
//   i_async : raw asynchronous PWM line
//   o_level : synchronized level
//   o_rise  : one-cycle pulse on a synchronized rising edge
//   o_fall  : one-cycle pulse on a synchronized falling edge
// Edges are suppressed until the chain has refilled after reset, so a line
// that is already high when reset drops does not look like a fresh rise.
module pwm_edge_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic       r_meta;
    logic       r_sync;
    logic       r_prev;
    logic [1:0] r_fill;
    logic       w_armed;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
            r_fill <= 2'd0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
            if (r_fill != 2'd3) begin
                r_fill <= r_fill + 2'd1;
            end
        end
    end

    assign w_armed = (r_fill == 2'd3);
    assign o_level = r_sync;
    assign o_rise  = w_armed & r_sync & ~r_prev;
    assign o_fall  = w_armed & ~r_sync & r_prev;

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: measures high time and period of the servo PWM line in ticks.
//   CLK         : system clock
//   RST         : asynchronous active-high reset
//   EN          : capture enable
//   PWM_IN      : asynchronous PWM input
//   pulse_width : last measured high time (ticks)
//   period      : last measured rise-to-rise time (ticks)
//   valid       : one-cycle strobe when pulse_width/period update
//   in_range    : last pulse_width within [PW_MIN, PW_MAX]
//   timeout     : no complete period within PERIOD_MAX ticks (sticky until next publish)
//   direction   : change vs previous pulse (stop / CCW = wider / CW = narrower)
module pwm_capture
    import solar_tracker_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 100,
    parameter int unsigned PW_MIN     = PW_MIN_DEFAULT,
    parameter int unsigned PW_MAX     = PW_MAX_DEFAULT,
    parameter int unsigned PERIOD_MAX = 25000,
    parameter int unsigned DEADBAND   = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        EN,
    input  logic        PWM_IN,
    output logic [31:0] pulse_width,
    output logic [31:0] period,
    output logic        valid,
    output logic        in_range,
    output logic        timeout,
    output logic [1:0]  direction
);

    localparam logic [31:0] LP_DIV_LAST = 32'(CLK_DIV - 1);
    localparam logic [31:0] LP_PER_MAX  = 32'(PERIOD_MAX);
    localparam logic [31:0] LP_PW_MIN   = 32'(PW_MIN);
    localparam logic [31:0] LP_PW_MAX   = 32'(PW_MAX);
    localparam logic [31:0] LP_DB       = 32'(DEADBAND);

    logic        w_level;
    logic        w_rise;
    logic        w_fall;
    logic        w_tick;
    logic        w_unused_level;
    logic [31:0] w_hi_next;
    logic [31:0] w_lo_next;
    logic [31:0] w_idle_next;
    logic [31:0] w_hi_sum;
    logic [31:0] w_lo_sum;

    pwm_state_e  r_state;
    logic [31:0] r_presc;
    logic [31:0] r_hi_cnt;
    logic [31:0] r_lo_cnt;
    logic [31:0] r_idle_cnt;
    logic        r_have_prev;

    pwm_edge_sync u_edge_sync (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_async (PWM_IN),
        .o_level (w_level),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    assign w_unused_level = w_level;

    // The tick of the cycle carrying an edge still counts toward the level
    // that is ending, so a level of H cycles measures floor(H / CLK_DIV).
    assign w_tick      = (r_presc == LP_DIV_LAST);
    assign w_hi_next   = sat_inc(r_hi_cnt, w_tick, LP_PER_MAX);
    assign w_lo_next   = sat_inc(r_lo_cnt, w_tick, LP_PER_MAX);
    assign w_idle_next = sat_inc(r_idle_cnt, w_tick, LP_PER_MAX);
    assign w_hi_sum    = w_hi_next + r_lo_cnt;
    assign w_lo_sum    = r_hi_cnt + w_lo_next;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= StIdle;
            r_presc     <= '0;
            r_hi_cnt    <= '0;
            r_lo_cnt    <= '0;
            r_idle_cnt  <= '0;
            r_have_prev <= 1'b0;
            pulse_width <= '0;
            period      <= '0;
            valid       <= 1'b0;
            in_range    <= 1'b0;
            timeout     <= 1'b0;
            direction   <= DIR_STOP;
        end else begin
            valid <= 1'b0;
            if (w_rise || w_fall || w_tick) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + 32'd1;
            end

            if (!EN) begin
                r_state     <= StIdle;
                r_presc     <= '0;
                r_hi_cnt    <= '0;
                r_lo_cnt    <= '0;
                r_idle_cnt  <= '0;
                r_have_prev <= 1'b0;
            end else begin
                case (r_state)
                    StIdle: begin
                        r_have_prev <= 1'b0;
                        if (w_rise) begin
                            r_state    <= StHigh;
                            r_hi_cnt   <= '0;
                            r_lo_cnt   <= '0;
                            r_idle_cnt <= '0;
                        end else begin
                            r_idle_cnt <= w_idle_next;
                            if (w_idle_next >= LP_PER_MAX) begin
                                timeout <= 1'b1;
                            end
                        end
                    end
                    StHigh: begin
                        if (w_hi_sum >= LP_PER_MAX) begin
                            timeout    <= 1'b1;
                            r_state    <= StIdle;
                            r_hi_cnt   <= '0;
                            r_lo_cnt   <= '0;
                            r_idle_cnt <= '0;
                        end else begin
                            r_hi_cnt <= w_hi_next;
                            if (w_fall) begin
                                r_state <= StLow;
                            end
                        end
                    end
                    StLow: begin
                        if (w_lo_sum >= LP_PER_MAX) begin
                            timeout    <= 1'b1;
                            r_state    <= StIdle;
                            r_hi_cnt   <= '0;
                            r_lo_cnt   <= '0;
                            r_idle_cnt <= '0;
                        end else if (w_rise) begin
                            // Publish the closed period and start the next one.
                            pulse_width <= r_hi_cnt;
                            period      <= w_lo_sum;
                            valid       <= 1'b1;
                            in_range    <= (r_hi_cnt >= LP_PW_MIN) && (r_hi_cnt <= LP_PW_MAX);
                            direction   <= r_have_prev ?
                                           pwm_direction(r_hi_cnt, pulse_width, LP_DB) : DIR_STOP;
                            timeout     <= 1'b0;
                            r_have_prev <= 1'b1;
                            r_state     <= StHigh;
                            r_hi_cnt    <= '0;
                            r_lo_cnt    <= '0;
                        end else begin
                            r_lo_cnt <= w_lo_next;
                        end
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture. Waveform timing is scaled down by 10x
// from the nominal 20 ms servo frame (limits scaled to match) to keep the run short.
module tb_pwm_capture;

    localparam int unsigned CLK_DIV    = 2;
    localparam int unsigned PW_MIN     = 50;
    localparam int unsigned PW_MAX     = 250;
    localparam int unsigned PERIOD_MAX = 2500;
    localparam int unsigned DEADBAND   = 2;

    logic        CLK = 1'b0;
    logic        RST;
    logic        EN;
    logic        PWM_IN;
    logic [31:0] pulse_width;
    logic [31:0] period;
    logic        valid;
    logic        in_range;
    logic        timeout;
    logic [1:0]  direction;

    pwm_capture #(
        .CLK_DIV    (CLK_DIV),
        .PW_MIN     (PW_MIN),
        .PW_MAX     (PW_MAX),
        .PERIOD_MAX (PERIOD_MAX),
        .DEADBAND   (DEADBAND)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .EN          (EN),
        .PWM_IN      (PWM_IN),
        .pulse_width (pulse_width),
        .period      (period),
        .valid       (valid),
        .in_range    (in_range),
        .timeout     (timeout),
        .direction   (direction)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int unsigned pw;
        int unsigned per;
        logic        rng;
        logic [1:0]  dir;
        int unsigned cyc;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned total = 0;
    int unsigned bad = 0;
    int unsigned cyc = 0;

    // Reference model state: the last complete (high, low) segment awaiting
    // its closing rise, and the previously published width.
    bit          pend_ok = 1'b0;
    int unsigned pend_h = 0;
    int unsigned pend_l = 0;
    bit          have_prev = 1'b0;
    int unsigned prev_pw = 0;
    int unsigned last_pw = 0;
    int unsigned last_per = 0;
    logic        valid_q = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    function automatic logic [1:0] ref_dir(input int unsigned nw, input int unsigned od);
        if (nw > od + DEADBAND) return 2'b01;
        if (nw + DEADBAND < od) return 2'b10;
        return 2'b00;
    endfunction

    // Monitor: every valid strobe is matched against the oldest expectation.
    always @(negedge CLK) begin
        exp_t e;
        if (valid === 1'b1) begin
            if (valid_q === 1'b1) begin
                check("valid_one_cycle", 64'(valid_q), 64'd0);
            end else if (exp_q.size() == 0) begin
                check("unexpected_valid", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                check("pulse_width", pulse_width, 64'(e.pw));
                check("period", period, 64'(e.per));
                check("in_range", 64'(in_range), 64'(e.rng));
                check("direction", 64'(direction), 64'(e.dir));
                check("timeout_at_valid", 64'(timeout), 64'd0);
                check("valid_latency", 64'(cyc), 64'(e.cyc));
            end
        end
        valid_q <= valid;
    end

    task automatic hold(input int unsigned n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Raise the line; if a full segment is pending this rise closes it.
    task automatic drive_rise();
        exp_t e;
        PWM_IN = 1'b1;
        if (pend_ok) begin
            e.pw  = pend_h / CLK_DIV;
            e.per = pend_h / CLK_DIV + pend_l / CLK_DIV;
            e.rng = (e.pw >= PW_MIN) && (e.pw <= PW_MAX);
            e.dir = have_prev ? ref_dir(e.pw, prev_pw) : 2'b00;
            e.cyc = cyc + 3;
            exp_q.push_back(e);
            have_prev = 1'b1;
            prev_pw   = e.pw;
            last_pw   = e.pw;
            last_per  = e.per;
        end
    endtask

    task automatic pulse(input int unsigned h, input int unsigned l);
        drive_rise();
        hold(h);
        PWM_IN = 1'b0;
        hold(l);
        pend_h  = h;
        pend_l  = l;
        pend_ok = 1'b1;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_pulse_width"}, pulse_width, 64'd0);
        check({tag, "_period"}, period, 64'd0);
        check({tag, "_valid"}, 64'(valid), 64'd0);
        check({tag, "_in_range"}, 64'(in_range), 64'd0);
        check({tag, "_timeout"}, 64'(timeout), 64'd0);
        check({tag, "_direction"}, 64'(direction), 64'd0);
    endtask

    int unsigned db_h[8] = '{320, 302, 300, 80, 600, 500, 100, 99};
    int unsigned db_l[8] = '{880, 898, 900, 1120, 600, 700, 1100, 1101};

    initial begin
        RST    = 1'b0;
        EN     = 1'b1;
        PWM_IN = 1'b0;
        #2 RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check_zero_outputs("reset");
        RST = 1'b0;
        hold(5);

        // Nominal frame: 150 ticks high, 2000 ticks period.
        pulse(300, 3700);
        pulse(300, 3700);

        // Deadband and range boundaries.
        for (int i = 0; i < 8; i++) begin
            pulse(db_h[i], db_l[i]);
        end

        // Random frames, all well inside the timeout limit.
        for (int i = 0; i < 12; i++) begin
            pulse($urandom_range(700, 20), $urandom_range(1500, 20));
        end

        // Line stuck high: timeout after PERIOD_MAX ticks, outputs hold.
        drive_rise();
        hold(4990);
        check("timeout_before_limit", 64'(timeout), 64'd0);
        hold(20);
        check("timeout_set", 64'(timeout), 64'd1);
        check("timeout_hold_pw", pulse_width, 64'(last_pw));
        check("timeout_hold_per", period, 64'(last_per));
        pend_ok   = 1'b0;
        have_prev = 1'b0;
        PWM_IN    = 1'b0;
        hold(200);
        pulse(300, 700);
        check("timeout_kept", 64'(timeout), 64'd1);
        pulse(310, 690);
        check("timeout_cleared", 64'(timeout), 64'd0);

        // Asynchronous reset in the middle of a high phase.
        pulse(300, 700);
        drive_rise();
        hold(200);
        #2 RST = 1'b1;
        #1;
        check_zero_outputs("async_rst");
        pend_ok   = 1'b0;
        have_prev = 1'b0;
        @(posedge CLK);
        #1 RST = 1'b0;
        hold(100);
        PWM_IN = 1'b0;
        hold(500);
        pulse(300, 3700);
        pulse(300, 700);

        // Enable dropped mid-period, then restored.
        pulse(200, 800);
        drive_rise();
        hold(200);
        PWM_IN = 1'b0;
        hold(300);
        EN        = 1'b0;
        pend_ok   = 1'b0;
        have_prev = 1'b0;
        hold(400);
        check("en_hold_pw", pulse_width, 64'(last_pw));
        check("en_hold_per", period, 64'(last_per));
        drive_rise();
        hold(200);
        PWM_IN = 1'b0;
        hold(300);
        EN = 1'b1;
        hold(300);
        pulse(240, 760);
        pulse(260, 740);
        pulse(240, 760);
        drive_rise();
        hold(20);

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
